shift_reg_universal: RTL
========================

// Module: shift_reg_universal
// PURPOSE
//  Parametrised universal shift register; successor to the fixed 6-bit serial-in shift chain.
//  Adds the following to a plain shift chain:
//   - a selectable width
//   - left/right shift, rotate, arithmetic right shift, parallel load and clear
//   - serial outputs at both ends
//   - a shift counter with a word-complete pulse for serialiser/deserialiser use
//  Sits between parallel datapath logic and serial links/LED chains in lab designs.
// PARAMETERS
//  WIDTH      6   register width in bits, legal range >= 2
//  RESET_VAL  0   value loaded into q on reset (WIDTH bits)
//  CW         $clog2(WIDTH+1)  localparam, shift_cnt width
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  en           in   1      operation enable; 0 = hold all state
//  mode         in   3      operation select (encodings below)
//  ser_in_l     in   1      serial bit entering at LSB on SHL
//  ser_in_r     in   1      serial bit entering at MSB on SHR
//  par_in       in   WIDTH  parallel load data
//  q            out  WIDTH  register contents
//  ser_out_msb  out  1      q[WIDTH-1], combinational from register
//  ser_out_lsb  out  1      q[0], combinational from register
//  shift_cnt    out  CW     shifts since last LOAD/CLEAR/wrap
//  word_done    out  1      1-cycle pulse after the WIDTH-th shift
// BEHAVIOUR
//  - Reset (reset_n=0, any time, no clock needed):
//    q=RESET_VAL, shift_cnt=0, word_done=0; held until reset_n=1.
//  - Latency: en/mode/data sampled at rising edge; q valid after that edge (1 cycle).
//  - en=0: q and shift_cnt hold; word_done=0.
//  - mode encodings (applied only when en=1):
//    000 HOLD   q unchanged, cnt unchanged
//    001 SHL    q <= {q[W-2:0], ser_in_l}
//    010 SHR    q <= {ser_in_r, q[W-1:1]}
//    011 ROL    q <= {q[W-2:0], q[W-1]}
//    100 ROR    q <= {q[0], q[W-1:1]}
//    101 ASR    q <= {q[W-1], q[W-1:1]}
//    110 LOAD   q <= par_in, cnt <= 0
//    111 CLEAR  q <= 0 (not RESET_VAL), cnt <= 0
//    All 8 codes are defined; there is no illegal mode.
//  - Counter:
//    - Each SHL/SHR/ROL/ROR/ASR edge increments shift_cnt.
//    - When cnt==WIDTH-1 and a shift occurs: cnt wraps to 0 and word_done is registered high
//      for exactly the following cycle.
//    - Back-to-back words therefore pulse every WIDTH shifts.
//  - word_done is registered and is 0 in every cycle not following a wrapping shift.
//  - LOAD/CLEAR at cnt==WIDTH-1: load/clear wins, cnt=0, no word_done.
//  - Reset asserted mid-word: counter and q cleared immediately; a pending word_done is dropped.
// STRUCTURE
//  - Package shift_reg_pkg holds the MODE_* 3-bit localparams (HOLD..CLEAR).
//    Decoders and benches share it.
//  - Sub-module shift_word_counter(WIDTH): holds shift_cnt and word_done.
//    Inputs: shift_evt and clr_evt.
//  - Data register and mode mux stay in the top module as a single always block
//    with asynchronous reset.
// TESTING (WIDTH=6, RESET_VAL=0)
//  1. q=101101 and cnt=3, then drop reset_n between edges
//     -> q=000000, cnt=0, word_done=0 at once, before the next edge.
//  2. LOAD 101100, then SHL with ser_in_l=1 -> q=011001, cnt=1;
//     ser_out_msb=0, ser_out_lsb=1.
//  3. LOAD 100110, then ASR -> q=110011; then SHR with ser_in_r=0 -> q=011001, cnt=2.
//  4. LOAD 100110, then ROL x6 -> q=100110, cnt=0.
//     word_done=1 only in the cycle after the 6th edge.
//  5. en=0 with mode=SHL for 3 edges -> q and cnt unchanged, word_done=0.
//     Then CLEAR with en=1 -> q=000000, cnt=0.
//  6. After 5 shifts (cnt=5), LOAD 111111 -> q=111111, cnt=0, word_done stays 0.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode encodings shared by shift_reg_universal, its decoders and benches
package shift_reg_pkg;
  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_ASR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;
endpackage

// File: rtl/shift_word_counter.sv
// shift_word_counter: counts shifts (shift_evt), restarts on clr_evt, wraps at WIDTH and pulses word_done for one cycle
module shift_word_counter #(
  parameter int WIDTH = 6,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          shift_evt,
  input  logic          clr_evt,
  output logic [CW-1:0] shift_cnt,
  output logic          word_done
);
  logic wrap;
  assign wrap = shift_evt && shift_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      shift_cnt <= clr_evt || wrap ? '0 : shift_evt ? shift_cnt + 1'b1 : shift_cnt;
      word_done <= wrap && !clr_evt;
    end
endmodule

// File: rtl/shift_reg_universal.sv
// shift_reg_universal: WIDTH-bit universal shift register (shift/rotate/asr/load/clear via mode when en) with serial taps and word counter
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);
  logic [WIDTH-1:0] nxt;
  logic shift_evt, clr_evt;
  always_comb begin
    nxt = mode == MODE_SHL   ? {q[WIDTH-2:0], ser_in_l} :
          mode == MODE_SHR   ? {ser_in_r, q[WIDTH-1:1]} :
          mode == MODE_ROL   ? {q[WIDTH-2:0], q[WIDTH-1]} :
          mode == MODE_ROR   ? {q[0], q[WIDTH-1:1]} :
          mode == MODE_ASR   ? {q[WIDTH-1], q[WIDTH-1:1]} :
          mode == MODE_LOAD  ? par_in :
          mode == MODE_CLEAR ? '0 : q;
    shift_evt = en && mode >= MODE_SHL && mode <= MODE_ASR;
    clr_evt = en && mode >= MODE_LOAD;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= RESET_VAL;
    else if (en) q <= nxt;
  assign ser_out_msb = q[WIDTH-1];
  assign ser_out_lsb = q[0];
  shift_word_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .shift_evt(shift_evt),
    .clr_evt(clr_evt),
    .shift_cnt(shift_cnt),
    .word_done(word_done)
  );
endmodule
